dope_motion: RTL and testbench

Player-physics stage for the dope sprite. Consumes the `grounded` flag produced by the floor stage. Produces `dope_x`, `dope_y` and `jump`, which feed back into the floor stage's landing test and into the sprite renderer. It runs horizontal walking, jump ascent, gravity fall with per-pixel landing detection, screen-bottom death and level respawn, all at a divided physics tick.

---
 rtl/dope_motion.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_dope_motion.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dope_motion.sv
// dope_motion: player physics for the dope sprite.
// Handles walking, jump ascent, gravity fall with per-pixel landing
// detection, screen-bottom death and level respawn. Physics runs on a
// divided tick. Each fall tick is spread over a burst of single-pixel
// steps, and the floor stage is consulted after every pixel.
// Priority order: reset, then level_load, then tick or step actions.
// The dbg_* outputs expose the FSM state and the internal vy/steps
// registers for observation.
`timescale 1ns/1ps

module dope_motion #(
    parameter int TICK_DIV = 1_000_000,
    parameter int X_START  = 100,
    parameter int Y_START  = 447,
    parameter int X_MIN    = 65,
    parameter int X_MAX    = 627,
    parameter int Y_TOP    = 60,
    parameter int Y_DEAD   = 479,
    parameter int STEP_X   = 2,
    parameter int JUMP_V0  = 12,
    parameter int VMAX     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       level_load,
    input  logic       grounded,
    output logic [9:0] dope_x,
    output logic [9:0] dope_y,
    output logic       jump,
    output logic       falling,
    output logic       dead,
    output logic [2:0] dbg_state_o,
    output logic [3:0] dbg_vy_o,
    output logic [3:0] dbg_steps_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    // Positions are extended to 11 bits so that clamping never sees a wrapped value.
    localparam logic [10:0] X_MIN_W  = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
    localparam logic [10:0] Y_TOP_W  = 11'(Y_TOP);
    localparam logic [10:0] Y_DEAD_W = 11'(Y_DEAD);
    localparam logic [10:0] STEP_W   = 11'(STEP_X);
    localparam logic [9:0]  X_MIN_N  = 10'(X_MIN);
    localparam logic [9:0]  X_MAX_N  = 10'(X_MAX);
    localparam logic [9:0]  Y_TOP_N  = 10'(Y_TOP);
    localparam logic [9:0]  X_START_N = 10'(X_START);
    localparam logic [9:0]  Y_START_N = 10'(Y_START);
    localparam logic [3:0]  JV0_N    = 4'(JUMP_V0);
    localparam logic [3:0]  VMAX_N   = 4'(VMAX);
    localparam logic [4:0]  VMAX_W   = 5'(VMAX);

    typedef enum logic [2:0] {
        S_GROUND    = 3'd0,
        S_RISE      = 3'd1,
        S_FALL      = 3'd2,
        S_FALL_STEP = 3'd3,
        S_DEAD      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          tick;
    logic          jl_q;
    logic          consume;

    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [3:0]    vy_q, vy_d;
    logic [3:0]    steps_q, steps_d;
    logic          jump_q, jump_d;
    logic          falling_q, falling_d;
    logic          dead_q, dead_d;

    // Shared arithmetic, computed once and used by both comb processes.
    logic [10:0]   x_ext, x_inc, x_dec;
    logic [10:0]   y_ext, y_sub, y_step;
    logic [4:0]    vy_inc;
    logic [9:0]    x_walk;
    logic [9:0]    y_rise;
    logic [3:0]    vy_fall;
    logic          step_kills;
    logic          rise_ends;

    assign tick    = (cnt_q == TICK_LAST);
    assign consume = tick && (state_q == S_GROUND) && jl_q;

    // Free-running physics tick divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Jump request latch. A pulse seen in the air stays pending until the next grounded tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            jl_q <= 1'b0;
        end else if (level_load) begin
            jl_q <= 1'b0;
        end else begin
            jl_q <= (jl_q & ~consume) | btn_jump;
        end
    end

    // Horizontal walk with saturation at both screen boundaries.
    always_comb begin
        x_ext  = {1'b0, x_q};
        x_inc  = x_ext + STEP_W;
        x_dec  = x_ext - STEP_W;
        x_walk = x_q;
        if (btn_right && !btn_left) begin
            x_walk = (x_inc > X_MAX_W) ? X_MAX_N : x_inc[9:0];
        end else if (btn_left && !btn_right) begin
            x_walk = (x_ext < (X_MIN_W + STEP_W)) ? X_MIN_N : x_dec[9:0];
        end
    end

    // Vertical helpers: rise clamped at the top, fall speed capped, single-pixel step.
    always_comb begin
        y_ext      = {1'b0, y_q};
        y_sub      = y_ext - {7'd0, vy_q};
        y_rise     = (y_ext < (Y_TOP_W + {7'd0, vy_q})) ? Y_TOP_N : y_sub[9:0];
        rise_ends  = (vy_q <= 4'd1);
        vy_inc     = {1'b0, vy_q} + 5'd1;
        vy_fall    = (vy_inc > VMAX_W) ? VMAX_N : vy_inc[3:0];
        y_step     = y_ext + 11'd1;
        step_kills = (y_step >= Y_DEAD_W);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_GROUND;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A tick landing in FALL_STEP or DEAD has no effect.
    always_comb begin
        state_d = state_q;
        if (level_load) begin
            state_d = S_GROUND;
        end else begin
            case (state_q)
                S_GROUND: begin
                    if (tick) begin
                        if (jl_q) begin
                            state_d = S_RISE;
                        end else if (!grounded) begin
                            state_d = S_FALL;
                        end
                    end
                end
                S_RISE: begin
                    if (tick && rise_ends) begin
                        state_d = S_FALL;
                    end
                end
                S_FALL: begin
                    if (tick) begin
                        state_d = S_FALL_STEP;
                    end
                end
                S_FALL_STEP: begin
                    if (grounded) begin
                        state_d = S_GROUND;
                    end else if (steps_q == 4'd0) begin
                        state_d = S_FALL;
                    end else if (step_kills) begin
                        state_d = S_DEAD;
                    end
                end
                S_DEAD: begin
                    state_d = S_DEAD;
                end
                default: begin
                    state_d = S_GROUND;
                end
            endcase
        end
    end

    // Output and datapath next values. Everything holds unless a tick or step acts.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        vy_d      = vy_q;
        steps_d   = steps_q;
        jump_d    = jump_q;
        falling_d = falling_q;
        dead_d    = dead_q;
        if (level_load) begin
            x_d       = X_START_N;
            y_d       = Y_START_N;
            vy_d      = 4'd0;
            steps_d   = 4'd0;
            jump_d    = 1'b0;
            falling_d = 1'b0;
            dead_d    = 1'b0;
        end else begin
            case (state_q)
                S_GROUND: begin
                    if (tick) begin
                        x_d = x_walk;
                        if (jl_q) begin
                            // The launch tick sets the speed only. Height starts changing on the next tick.
                            vy_d   = JV0_N;
                            jump_d = 1'b1;
                        end else if (!grounded) begin
                            vy_d      = 4'd0;
                            falling_d = 1'b1;
                        end
                    end
                end
                S_RISE: begin
                    // grounded is ignored here, so platforms can be passed from below.
                    if (tick) begin
                        x_d  = x_walk;
                        y_d  = y_rise;
                        vy_d = vy_q - 4'd1;
                        if (rise_ends) begin
                            vy_d      = 4'd0;
                            jump_d    = 1'b0;
                            falling_d = 1'b1;
                        end
                    end
                end
                S_FALL: begin
                    if (tick) begin
                        x_d     = x_walk;
                        vy_d    = vy_fall;
                        steps_d = vy_fall;
                    end
                end
                S_FALL_STEP: begin
                    // Move one pixel per clk. grounded is checked against the row just reached.
                    if (grounded) begin
                        vy_d      = 4'd0;
                        steps_d   = 4'd0;
                        falling_d = 1'b0;
                    end else if (steps_q != 4'd0) begin
                        y_d     = y_step[9:0];
                        steps_d = steps_q - 4'd1;
                        if (step_kills) begin
                            dead_d    = 1'b1;
                            falling_d = 1'b0;
                        end
                    end
                end
                default: begin
                    // In DEAD every output holds its value.
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= X_START_N;
            y_q       <= Y_START_N;
            vy_q      <= 4'd0;
            steps_q   <= 4'd0;
            jump_q    <= 1'b0;
            falling_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vy_q      <= vy_d;
            steps_q   <= steps_d;
            jump_q    <= jump_d;
            falling_q <= falling_d;
            dead_q    <= dead_d;
        end
    end

    assign dope_x      = x_q;
    assign dope_y      = y_q;
    assign jump        = jump_q;
    assign falling     = falling_q;
    assign dead        = dead_q;
    assign dbg_state_o = state_q;
    assign dbg_vy_o    = vy_q;
    assign dbg_steps_o = steps_q;

endmodule

// File: tb/tb_dope_motion.sv
// Testbench for dope_motion with TICK_DIV = 16.
// The floor stage is replaced by a small behavioural model.
// Expected output records are queued as the stimulus is driven.
// Each record is popped and compared once the DUT has acted on it.
`timescale 1ns/1ps

module tb_dope_motion;

    localparam int TICK_DIV = 16;

    logic       clk = 1'b0;
    logic       reset, btn_left, btn_right, btn_jump, level_load, grounded;
    logic [9:0] dope_x, dope_y;
    logic       jump, falling, dead;
    logic [2:0] dbg_state_o;
    logic [3:0] dbg_vy_o, dbg_steps_o;

    int checks = 0;
    int errors = 0;
    int floor_mode = 0;  // 0: rows 447..449, 1: no floor, 2: floor only at row 409
    int tb_cnt = 0;
    logic overlap_seen = 1'b0;

    logic [22:0] exp_q[$];

    typedef struct {
        logic       l;
        logic       r;
        logic [9:0] x;
    } walk_vec_t;

    dope_motion #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .btn_jump(btn_jump), .level_load(level_load), .grounded(grounded),
        .dope_x(dope_x), .dope_y(dope_y), .jump(jump), .falling(falling), .dead(dead),
        .dbg_state_o(dbg_state_o), .dbg_vy_o(dbg_vy_o), .dbg_steps_o(dbg_steps_o)
    );

    // Clock and tick reference
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) tb_cnt <= 0;
        else tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
    end

    // Floor-stage model
    always_comb begin
        case (floor_mode)
            1:       grounded = 1'b0;
            2:       grounded = !jump && (dope_y == 10'd409);
            default: grounded = !jump && (dope_y >= 10'd447) && (dope_y <= 10'd449);
        endcase
    end

    always @(negedge clk) begin
        if (jump && falling) overlap_seen <= 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic next_tick();
        do step_clk(); while (tb_cnt != 0);
    endtask

    task automatic tick_settle();
        next_tick();
        repeat (10) step_clk();
    endtask

    task automatic pulse_jump();
        btn_jump = 1'b1;
        step_clk();
        btn_jump = 1'b0;
    endtask

    task automatic pulse_load();
        level_load = 1'b1;
        step_clk();
        level_load = 1'b0;
    endtask

    // Scoreboard
    task automatic expect_out(input int x, input int y, input logic j, input logic f, input logic d);
        logic [9:0] xs, ys;
        xs = x[9:0];
        ys = y[9:0];
        exp_q.push_back({xs, ys, j, f, d});
    endtask

    task automatic check_out(input string name);
        logic [22:0] e, a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard queue empty", name);
            return;
        end
        e = exp_q.pop_front();
        a = {dope_x, dope_y, jump, falling, dead};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d jump=%0b falling=%0b dead=%0b, want x=%0d y=%0d jump=%0b falling=%0b dead=%0b",
                     name, a[22:13], a[12:3], a[2], a[1], a[0], e[22:13], e[12:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    initial begin
        int rise_y[11];
        int fall_y[13];
        int death_y[7];
        walk_vec_t wv[11];

        rise_y  = '{435, 424, 414, 405, 397, 390, 384, 379, 375, 372, 370};
        fall_y  = '{370, 372, 375, 379, 384, 390, 397, 405, 413, 421, 429, 437, 445};
        death_y = '{448, 450, 453, 457, 462, 468, 475};
        wv[0]  = '{1'b0, 1'b1, 10'd622};
        wv[1]  = '{1'b0, 1'b1, 10'd624};
        wv[2]  = '{1'b0, 1'b1, 10'd626};
        wv[3]  = '{1'b0, 1'b1, 10'd627};
        wv[4]  = '{1'b0, 1'b1, 10'd627};
        wv[5]  = '{1'b1, 1'b1, 10'd627};
        wv[6]  = '{1'b0, 1'b0, 10'd627};
        wv[7]  = '{1'b1, 1'b0, 10'd68};
        wv[8]  = '{1'b1, 1'b0, 10'd66};
        wv[9]  = '{1'b1, 1'b0, 10'd65};
        wv[10] = '{1'b1, 1'b0, 10'd65};

        // Reset and idle
        reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0; level_load = 1'b0;
        repeat (2) step_clk();
        reset = 1'b0;
        expect_out(100, 447, 0, 0, 0);
        check_out("reset");
        check_val("reset_state", int'(dbg_state_o), 0);
        for (int i = 0; i < 40; i++) begin
            step_clk();
            expect_out(100, 447, 0, 0, 0);
            check_out("idle");
        end

        // Jump arc
        pulse_jump();
        expect_out(100, 447, 1, 0, 0);
        next_tick();
        check_out("jump_start");
        for (int i = 0; i < 11; i++) begin
            expect_out(100, rise_y[i], 1, 0, 0);
            next_tick();
            check_out("rise");
        end
        expect_out(100, 369, 0, 1, 0);
        next_tick();
        check_out("apex");
        for (int i = 0; i < 13; i++) begin
            expect_out(100, fall_y[i], 0, 1, 0);
            tick_settle();
            check_out("fall");
        end
        expect_out(100, 447, 0, 0, 0);
        tick_settle();
        check_out("land");
        check_val("land_state", int'(dbg_state_o), 0);
        check_val("no_overlap", int'(overlap_seen), 0);

        // Walk clamp
        btn_right = 1'b1;
        expect_out(620, 447, 0, 0, 0);
        repeat (260) next_tick();
        check_out("walk_to_620");
        for (int i = 0; i < 11; i++) begin
            if (i == 7) begin
                btn_left = 1'b0; btn_right = 1'b0;
                expect_out(100, 447, 0, 0, 0);
                pulse_load();
                check_out("walk_load");
                btn_left = 1'b1;
                expect_out(70, 447, 0, 0, 0);
                repeat (15) next_tick();
                check_out("walk_to_70");
            end
            btn_left  = wv[i].l;
            btn_right = wv[i].r;
            expect_out(int'(wv[i].x), 447, 0, 0, 0);
            next_tick();
            check_out("walk_tbl");
        end
        btn_left = 1'b0; btn_right = 1'b0;

        // Mid-burst landing: the jump arc takes vy to 8 by row 405, and the floor sits at row 409.
        expect_out(100, 447, 0, 0, 0);
        pulse_load();
        check_out("mb_load");
        pulse_jump();
        expect_out(100, 447, 1, 0, 0);
        next_tick();
        check_out("mb_jump");
        floor_mode = 2;
        repeat (12) next_tick();
        for (int i = 0; i < 8; i++) tick_settle();
        expect_out(100, 405, 0, 1, 0);
        check_out("mb_at_405");
        check_val("mb_vy8", int'(dbg_vy_o), 8);
        next_tick();
        repeat (4) step_clk();
        expect_out(100, 409, 0, 1, 0);
        check_out("mb_reach_409");
        check_val("mb_steps_left", int'(dbg_steps_o), 4);
        check_val("mb_in_burst", int'(dbg_state_o), 3);
        step_clk();
        expect_out(100, 409, 0, 0, 0);
        check_out("mb_landed");
        check_val("mb_state", int'(dbg_state_o), 0);
        check_val("mb_vy0", int'(dbg_vy_o), 0);
        check_val("mb_steps0", int'(dbg_steps_o), 0);
        repeat (8) step_clk();
        expect_out(100, 409, 0, 0, 0);
        check_out("mb_hold");

        // Death and respawn
        floor_mode = 1;
        expect_out(100, 447, 0, 0, 0);
        pulse_load();
        check_out("dth_load");
        expect_out(100, 447, 0, 1, 0);
        next_tick();
        check_out("walk_off");
        for (int i = 0; i < 7; i++) begin
            expect_out(100, death_y[i], 0, 1, 0);
            tick_settle();
            check_out("dth_fall");
        end
        expect_out(100, 479, 0, 0, 1);
        tick_settle();
        check_out("dead");
        check_val("dead_state", int'(dbg_state_o), 4);
        btn_right = 1'b1;
        pulse_jump();
        for (int i = 0; i < 3; i++) begin
            expect_out(100, 479, 0, 0, 1);
            next_tick();
            check_out("frozen");
        end
        btn_right = 1'b0;
        floor_mode = 0;
        expect_out(100, 447, 0, 0, 0);
        pulse_load();
        check_out("respawn");
        expect_out(100, 447, 0, 0, 0);
        next_tick();
        next_tick();
        check_out("respawn_no_jump");

        // level_load and btn_jump in the same cycle
        btn_jump = 1'b1;
        expect_out(100, 447, 0, 0, 0);
        pulse_load();
        btn_jump = 1'b0;
        check_out("load_jump");
        for (int i = 0; i < 2; i++) begin
            expect_out(100, 447, 0, 0, 0);
            next_tick();
            check_out("load_jump_dropped");
        end

        // reset during a fall-step burst
        floor_mode = 1;
        next_tick();
        tick_settle();
        tick_settle();
        next_tick();
        step_clk();
        expect_out(100, 451, 0, 1, 0);
        check_out("rst_mid_burst");
        check_val("rst_in_burst", int'(dbg_state_o), 3);
        reset = 1'b1;
        step_clk();
        expect_out(100, 447, 0, 0, 0);
        check_out("rst_values");
        check_val("rst_state", int'(dbg_state_o), 0);
        floor_mode = 0;
        reset = 1'b0;
        expect_out(100, 447, 0, 0, 0);
        next_tick();
        check_out("rst_after");

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
